// File: rtl/decode_pkg.sv
// Shared definitions for the LEGv8 decode stage: opcode constants, ALU op
// encodings, the XZR index and the decoded control bundle.
package decode_pkg;

  localparam logic [4:0] XZR = 5'd31;

  localparam logic [1:0] ALU_MEM   = 2'b00;
  localparam logic [1:0] ALU_CBR   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_ALU12 = 3'd1,
    IMM_D9    = 3'd2,
    IMM_CB19  = 3'd3,
    IMM_B26   = 3'd4
  } imm_sel_e;

  // Control signals that travel to execute with the bundle.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       b;
    logic       cbz;
    logic       cbnz;
    logic       illegal;
  } ctrl_t;

  // Decode-local information that never leaves the stage.
  typedef struct packed {
    ctrl_t    ctrl;
    logic     reg2loc;
    logic     rs2_used;
    imm_sel_e imm_sel;
  } dec_t;

  function automatic dec_t decode_ctrl(input logic [10:0] opc);
    dec_t d;
    d = '0;
    casez (opc)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        d.ctrl.alu_op    = ALU_RTYPE;
        d.ctrl.reg_write = 1'b1;
        d.rs2_used       = 1'b1;
      end
      11'b1001000100?, 11'b1101000100?: begin
        d.ctrl.alu_op    = ALU_ITYPE;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.imm_sel        = IMM_ALU12;
      end
      OP_LDUR: begin
        d.ctrl.alu_op     = ALU_MEM;
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.mem_read   = 1'b1;
        d.ctrl.mem_to_reg = 1'b1;
        d.ctrl.reg_write  = 1'b1;
        d.imm_sel         = IMM_D9;
      end
      OP_STUR: begin
        d.ctrl.alu_op    = ALU_MEM;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.mem_write = 1'b1;
        d.reg2loc        = 1'b1;
        d.rs2_used       = 1'b1;
        d.imm_sel        = IMM_D9;
      end
      11'b10110100???: begin
        d.ctrl.alu_op = ALU_CBR;
        d.ctrl.cbz    = 1'b1;
        d.reg2loc     = 1'b1;
        d.rs2_used    = 1'b1;
        d.imm_sel     = IMM_CB19;
      end
      11'b10110101???: begin
        d.ctrl.alu_op = ALU_CBR;
        d.ctrl.cbnz   = 1'b1;
        d.reg2loc     = 1'b1;
        d.rs2_used    = 1'b1;
        d.imm_sel     = IMM_CB19;
      end
      11'b000101?????: begin
        d.ctrl.b  = 1'b1;
        d.imm_sel = IMM_B26;
      end
      default: begin
        d.ctrl.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// NREGS x XLEN register file, two combinational read ports, one write port,
// hard-wired XZR; optional write-before-read bypass under DECODE_WB_BYPASS_EN.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Register storage; XZR is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != XZR)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports; the XZR check has priority over any bypass.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
`ifdef DECODE_WB_BYPASS_EN
    rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : rdata1_o;
    rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : rdata2_o;
`endif
    rdata1_o = (raddr1_i == XZR) ? '0 : rdata1_o;
    rdata2_o = (raddr2_i == XZR) ? '0 : rdata2_o;
  end

endmodule

// File: rtl/decode_stage.sv
// LEGv8 decode stage: control decode, operand read, immediate build and a
// registered output bundle with load-use stall and flush. Option: DECODE_WB_BYPASS_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int ILEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [ILEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      id_rd,
  output logic [XLEN-1:0] id_rdata1,
  output logic [XLEN-1:0] id_rdata2,
  output logic [XLEN-1:0] id_imm,
  output logic [1:0]      id_alu_op,
  output logic            id_alu_src,
  output logic            id_mem_read,
  output logic            id_mem_write,
  output logic            id_mem_to_reg,
  output logic            id_reg_write,
  output logic            id_b,
  output logic            id_cbz,
  output logic            id_cbnz,
  output logic            id_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            flush
);

  dec_t            dec_s;
  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic            stall_s;
  logic            accept_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] rdata1_s;
  logic [XLEN-1:0] rdata2_s;

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rdata1_q;
  logic [XLEN-1:0] rdata2_q;
  logic [XLEN-1:0] imm_q;
  ctrl_t           ctrl_q;

  assign dec_s = decode_ctrl(if_instr[31:21]);
  assign rs1_s = if_instr[9:5];
  assign rs2_s = dec_s.reg2loc ? if_instr[4:0] : if_instr[20:16];

  // rs1 is compared unconditionally; rs2 only when the instruction reads it.
  assign stall_s = ex_mem_read && (ex_rd != XZR) &&
                   ((ex_rd == rs1_s) || (dec_s.rs2_used && (ex_rd == rs2_s)));

  assign if_ready = !stall_s && !flush && (!valid_q || id_ready);
  assign accept_s = if_valid && if_ready;

  decode_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_en),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr1_i (rs1_s),
    .raddr2_i (rs2_s),
    .rdata1_o (rdata1_s),
    .rdata2_o (rdata2_s)
  );

  // Immediate extraction and extension by instruction format.
  always_comb begin
    imm_s = '0;
    case (dec_s.imm_sel)
      IMM_ALU12: imm_s = {{(XLEN-12){1'b0}}, if_instr[21:10]};
      IMM_D9:    imm_s = {{(XLEN-9){if_instr[20]}}, if_instr[20:12]};
      IMM_CB19:  imm_s = {{(XLEN-19){if_instr[23]}}, if_instr[23:5]};
      IMM_B26:   imm_s = {{(XLEN-26){if_instr[25]}}, if_instr[25:0]};
      default:   imm_s = '0;
    endcase
  end

  // Output bundle: flush beats accept, accept beats drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rd_q     <= 5'd0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      ctrl_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept_s) begin
      valid_q  <= 1'b1;
      pc_q     <= if_pc;
      rd_q     <= if_instr[4:0];
      rdata1_q <= rdata1_s;
      rdata2_q <= rdata2_s;
      imm_q    <= imm_s;
      ctrl_q   <= dec_s.ctrl;
    end else if (id_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign id_valid      = valid_q;
  assign id_pc         = pc_q;
  assign id_rd         = rd_q;
  assign id_rdata1     = rdata1_q;
  assign id_rdata2     = rdata2_q;
  assign id_imm        = imm_q;
  assign id_alu_op     = ctrl_q.alu_op;
  assign id_alu_src    = ctrl_q.alu_src;
  assign id_mem_read   = ctrl_q.mem_read;
  assign id_mem_write  = ctrl_q.mem_write;
  assign id_mem_to_reg = ctrl_q.mem_to_reg;
  assign id_reg_write  = ctrl_q.reg_write;
  assign id_b          = ctrl_q.b;
  assign id_cbz        = ctrl_q.cbz;
  assign id_cbnz       = ctrl_q.cbnz;
  assign id_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic against a behavioural model of the decode stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        id_valid, id_ready;
  logic [63:0] id_pc, id_rdata1, id_rdata2, id_imm;
  logic [4:0]  id_rd;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write;
  logic        id_b, id_cbz, id_cbnz, id_illegal;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        flush;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .NREGS(32), .ILEN(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write), .id_b(id_b),
    .id_cbz(id_cbz), .id_cbnz(id_cbnz), .id_illegal(id_illegal), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .flush(flush)
  );

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] imm;
    logic [1:0]  alu_op;
    logic        alu_src, mr, mw, m2r, rw, b, cbz, cbnz, ill;
  } bun_t;

  bun_t        exp_q;
  logic [63:0] mregs [32];

  function automatic bun_t obs();
    return {id_valid, id_pc, id_rd, id_rdata1, id_rdata2, id_imm, id_alu_op,
            id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write,
            id_b, id_cbz, id_cbnz, id_illegal};
  endfunction

  // Field value as a signed integer of the given bit width.
  function automatic longint sext(input longint v, input int bits);
    return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
  endfunction

  // Reference decode from the instruction-set table.
  function automatic void mdec(input logic [31:0] ins, output bun_t o,
                               output logic r2l, output logic used2);
    int op;
    op = int'(ins[31:21]);
    o = '0;
    o.valid = 1'b1;
    o.rd = ins[4:0];
    r2l = 1'b0;
    used2 = 1'b0;
    if (op == 'h458 || op == 'h658 || op == 'h450 || op == 'h550) begin
      o.alu_op = 2'd2; o.rw = 1'b1; used2 = 1'b1;
    end else if ((op >> 1) == 'h244 || (op >> 1) == 'h344) begin
      o.alu_op = 2'd3; o.alu_src = 1'b1; o.rw = 1'b1;
      o.imm = 64'(ins[21:10]);
    end else if (op == 'h7C2) begin
      o.alu_op = 2'd0; o.alu_src = 1'b1; o.mr = 1'b1; o.m2r = 1'b1; o.rw = 1'b1;
      o.imm = 64'(sext(longint'(ins[20:12]), 9));
    end else if (op == 'h7C0) begin
      o.alu_op = 2'd0; o.alu_src = 1'b1; o.mw = 1'b1; r2l = 1'b1; used2 = 1'b1;
      o.imm = 64'(sext(longint'(ins[20:12]), 9));
    end else if ((op >> 3) == 'hB4 || (op >> 3) == 'hB5) begin
      o.alu_op = 2'd1; r2l = 1'b1; used2 = 1'b1;
      o.cbz = ((op >> 3) == 'hB4); o.cbnz = ((op >> 3) == 'hB5);
      o.imm = 64'(sext(longint'(ins[23:5]), 19));
    end else if ((op >> 5) == 5) begin
      o.b = 1'b1;
      o.imm = 64'(sext(longint'(ins[25:0]), 26));
    end else begin
      o.ill = 1'b1;
    end
  endfunction

  function automatic logic [63:0] mread(input logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_addr == idx) return wb_data;
`endif
    return mregs[idx];
  endfunction

  // One clock: check if_ready, advance the model, check the bundle after the edge.
  task automatic cycle(input string tag);
    bun_t nb, got;
    logic r2l, used2, stall, er;
    logic [4:0] rs1, rs2;
    #1;
    mdec(if_instr, nb, r2l, used2);
    rs1 = if_instr[9:5];
    rs2 = r2l ? if_instr[4:0] : if_instr[20:16];
    stall = ex_mem_read && ex_rd != 5'd31 && (ex_rd == rs1 || (used2 && ex_rd == rs2));
    er = !stall && !flush && (!exp_q.valid || id_ready);
    checks++;
    if (if_ready !== er) begin
      failures++;
      $display("FAIL %s if_ready got=%b exp=%b", tag, if_ready, er);
    end
    nb.pc = if_pc;
    nb.r1 = mread(rs1);
    nb.r2 = mread(rs2);
    if (rst) begin
      exp_q = '0;
      for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    end else begin
      if (flush) exp_q.valid = 1'b0;
      else if (if_valid && er) exp_q = nb;
      else if (id_ready) exp_q.valid = 1'b0;
      if (wb_en && wb_addr != 5'd31) mregs[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
    got = obs();
    checks++;
    if (got !== exp_q) begin
      failures++;
      $display("FAIL %s bundle got=%h exp=%h", tag, got, exp_q);
    end
  endtask

  task automatic idle();
    rst = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 64'd0; id_ready = 1'b1;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 64'd0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    flush = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wb(input logic [4:0] a, input logic [63:0] d);
    idle(); wb_en = 1'b1; wb_addr = a; wb_data = d;
    cycle("wb");
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; if_valid = 1'b1; if_instr = 32'h8B020023; if_pc = 64'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_q = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    cycle("reset");
    chk("reset_valid", 64'(id_valid), 64'd0);
    rst = 1'b0;
    cycle("pre_mid_reset");
    id_ready = 1'b0; rst = 1'b1;
    cycle("mid_reset");
    chk("mid_reset_valid", 64'(id_valid), 64'd0);
    chk("mid_reset_pc", id_pc, 64'd0);
    idle();
    cycle("post_reset");
  endtask

  task automatic test_add();
    wb(5'd1, 64'd5);
    wb(5'd2, 64'd7);
    idle(); if_valid = 1'b1; if_instr = 32'h8B020023; if_pc = 64'h200;
    cycle("add");
    chk("add_r1", id_rdata1, 64'd5);
    chk("add_r2", id_rdata2, 64'd7);
    chk("add_aluop", 64'(id_alu_op), 64'd2);
    chk("add_rw", 64'(id_reg_write), 64'd1);
    chk("add_rd", 64'(id_rd), 64'd3);
  endtask

  task automatic test_load_use();
    idle(); if_valid = 1'b1; if_instr = {11'h7C2, 9'h1F8, 2'b00, 5'd1, 5'd4}; if_pc = 64'h204;
    cycle("ldur");
    chk("ldur_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_mr", 64'(id_mem_read), 64'd1);
    chk("ldur_m2r", 64'(id_mem_to_reg), 64'd1);
    if_instr = {11'h458, 5'd1, 6'd0, 5'd4, 5'd5}; if_pc = 64'h208;
    ex_mem_read = 1'b1; ex_rd = 5'd4;
    #1;
    chk("lu_if_ready", 64'(if_ready), 64'd0);
    cycle("lu_stall");
    chk("lu_bubble", 64'(id_valid), 64'd0);
    ex_mem_read = 1'b0;
    cycle("lu_release");
    chk("lu_issue_rd", 64'(id_rd), 64'd5);
  endtask

  task automatic test_cbz();
    idle(); if_valid = 1'b1; if_instr = {8'hB4, 19'h7FFFF, 5'd2}; if_pc = 64'h300;
    cycle("cbz");
    chk("cbz_flag", 64'(id_cbz), 64'd1);
    chk("cbz_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("cbz_r2", id_rdata2, 64'd7);
  endtask

  task automatic test_hold_flush();
    bun_t snap;
    idle(); if_valid = 1'b1; if_instr = {10'h244, 12'hABC, 5'd2, 5'd9}; if_pc = 64'h400;
    cycle("hold_load");
    snap = obs();
    id_ready = 1'b0; if_instr = 32'h8B020023; if_pc = 64'h404;
    for (int i = 0; i < 3; i++) begin
      cycle("hold");
      checks++;
      if (obs() !== snap) begin
        failures++;
        $display("FAIL hold_stable got=%h exp=%h", obs(), snap);
      end
    end
    flush = 1'b1;
    cycle("flush");
    chk("flush_valid", 64'(id_valid), 64'd0);
    idle();
  endtask

  task automatic test_xzr_bypass();
    wb(5'd31, 64'hDEAD);
    idle(); if_valid = 1'b1; if_instr = {11'h458, 5'd31, 6'd0, 5'd31, 5'd7};
    cycle("xzr");
    chk("xzr_r1", id_rdata1, 64'd0);
    chk("xzr_r2", id_rdata2, 64'd0);
    wb(5'd6, 64'd3);
    idle(); if_valid = 1'b1; if_instr = {11'h458, 5'd6, 6'd0, 5'd6, 5'd8};
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 64'd9;
    cycle("bypass");
`ifdef DECODE_WB_BYPASS_EN
    chk("bypass_r1", id_rdata1, 64'd9);
`else
    chk("bypass_r1", id_rdata1, 64'd3);
`endif
    idle();
    cycle("after_bypass");
  endtask

  task automatic test_illegal();
    idle(); if_valid = 1'b1; if_instr = {11'h7FF, 21'd0};
    cycle("illegal");
    chk("ill_flag", 64'(id_illegal), 64'd1);
    chk("ill_rw", 64'(id_reg_write), 64'd0);
    chk("ill_mw", 64'(id_mem_write), 64'd0);
    idle();
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      case ($urandom_range(0, 11))
        0:  if_instr = {11'h458, r[20:0]};
        1:  if_instr = {11'h658, r[20:0]};
        2:  if_instr = {11'h450, r[20:0]};
        3:  if_instr = {11'h550, r[20:0]};
        4:  if_instr = {10'h244, r[21:0]};
        5:  if_instr = {10'h344, r[21:0]};
        6:  if_instr = {11'h7C2, r[20:0]};
        7:  if_instr = {11'h7C0, r[20:0]};
        8:  if_instr = {7'h5A, r[24:0]};
        9:  if_instr = {6'b000101, r[25:0]};
        default: if_instr = $urandom;
      endcase
      rst = ($urandom_range(0, 59) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc = {$urandom, $urandom};
      id_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      wb_en = $urandom_range(0, 1) == 1;
      wb_addr = $urandom_range(0, 1) == 1 ? if_instr[9:5] : 5'($urandom_range(0, 31));
      wb_data = {$urandom, $urandom};
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_rd = $urandom_range(0, 1) == 1 ? if_instr[9:5] : 5'($urandom_range(0, 31));
      cycle("random");
    end
    idle();
  endtask

  initial begin
    idle();
    exp_q = '0;
    test_reset();
    test_add();
    test_load_use();
    test_cbz();
    test_hold_flush();
    test_xzr_bypass();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Parametrised, pipelined LEGv8 instruction-decode stage with an integrated register file.
- Accepts instruction/PC from fetch over valid/ready; decodes control; reads two operands; builds the immediate; presents one registered bundle to execute.
- Adds a writeback port, load-use stall, branch flush and X31 zero-register semantics.
- Sits between fetch and execution.

Parameters:
XLEN, 64, datapath/register width in bits
NREGS, 32, number of architectural registers (index NREGS-1 is XZR)
ILEN, 32, instruction width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
if_valid  in  1  fetch bundle valid
if_ready  out  1  decode accepts fetch bundle this cycle
if_instr  in  ILEN  instruction
if_pc  in  XLEN  instruction address
id_valid  out  1  decoded bundle valid
id_ready  in  1  execute accepts bundle
id_pc  out  XLEN  registered PC
id_rd  out  5  destination register, instr[4:0]
id_rdata1  out  XLEN  Regs[instr[9:5]]
id_rdata2  out  XLEN  Regs[reg2loc ? instr[4:0] : instr[20:16]]
id_imm  out  XLEN  extended immediate
id_alu_op  out  2  00 mem, 01 cond-branch, 10 R-type, 11 I-type
id_alu_src  out  1  1 = immediate operand
id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write  out  1 each  control
id_b, id_cbz, id_cbnz  out  1 each  branch class
id_illegal  out  1  unrecognised opcode
wb_en  in  1  register write enable
wb_addr  in  5  write index
wb_data  in  XLEN  write data
ex_mem_read  in  1  instruction in execute is a load
ex_rd  in  5  its destination
flush  in  1  taken branch; kill pending decode

Behaviour:
- Reset:
  - All outputs 0; id_valid=0.
  - All registers cleared.
  - Reset mid-transfer drops the bundle.
- Accept:
  - if_ready = !stall & !flush & (!id_valid | id_ready).
  - On if_valid & if_ready, the output register loads the decoded bundle; id_valid=1 next cycle. Latency is 1 cycle.
- Hold: while id_valid & !id_ready, all id_* outputs are held stable.
- Stall (load-use):
  - Condition: ex_mem_read & ex_rd!=31 & (ex_rd==rs1 | (ex_rd==rs2 & rs2 used)).
  - if_ready=0 while stalled.
  - If id_ready, a bubble is inserted: id_valid=0 next cycle.
- Flush: id_valid cleared next cycle, overriding accept and hold. Flush and stall in the same cycle resolve to flush.
- Decode (opcode instr[31:21]):
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: alu_op 10, reg_write.
  - ADDI/SUBI 1001000100x/1101000100x: alu_op 11, alu_src, reg_write, imm = zext(instr[21:10]).
  - LDUR 11111000010: alu_op 00, alu_src, mem_read, mem_to_reg, reg_write, imm = sext(instr[20:12]).
  - STUR 11111000000: alu_op 00, alu_src, mem_write, reg2loc, imm = sext(instr[20:12]).
  - CBZ/CBNZ 10110100xxx/10110101xxx: alu_op 01, reg2loc, imm = sext(instr[23:5]).
  - B 000101xxxxx: id_b, imm = sext(instr[25:0]).
  - Anything else: id_illegal=1, all side-effect controls 0.
- Register file:
  - Write on clk when wb_en & wb_addr!=31.
  - Reads of index 31 return 0.
  - Writes to 31 are ignored.
  - Reads are captured at the accept edge.

Optional Feature:
DECODE_WB_BYPASS_EN.
- Defined: a read whose index equals wb_addr with wb_en=1 in the accept cycle returns wb_data (write-before-read).
- Undefined: the read returns the old register value; the writeback stage must avoid the conflict.

Decomposition:
- Package decode_pkg holds:
  - opcode constants and alu_op encodings;
  - XZR index;
  - a typedef for the control bundle.
- Sub-module decode_regfile: NREGS x XLEN, two read ports, one write port, XZR logic and the optional bypass.

Test Plan:
- Reset, then wb X1=5, X2=7; feed ADD X3,X1,X2 (0x8B020023) -> next cycle id_rdata1=5, id_rdata2=7, id_alu_op=10, id_reg_write=1, id_rd=3.
- LDUR X4,[X1,#-8] -> id_imm=0xFFFF_FFFF_FFFF_FFF8, mem_read=1, mem_to_reg=1. Then ex_mem_read=1, ex_rd=4 with ADD X5,X4,X1 -> if_ready=0 for one cycle and a bubble issues.
- CBZ X2 with offset -1 (instr[23:5] all ones) -> id_cbz=1, id_imm=all ones, id_rdata2 = X2 value.
- id_ready=0 for 3 cycles -> id_* outputs unchanged. Assert flush -> id_valid=0 next cycle.
- wb to X31 with 0xDEAD, then read X31 -> 0. Same-cycle wb X6=9 with read X6 -> 9 with DECODE_WB_BYPASS_EN defined, old value without it.
- Opcode 0x7FF -> id_illegal=1, reg_write=0, mem_write=0.
